ts_split_x50: RTL

TS_SPLIT_X50 -- requirements
Module: ts_split_x50

---
 rtl/tdc_pkg.sv | 15 +
 rtl/ts_split_x50.sv | 89 ++++++++
 2 files changed

// File: rtl/tdc_pkg.sv
// tdc_pkg: shared TDC timestamp widths, divisor default and splitter FSM states.
package tdc_pkg;

    localparam int DEF_TS_W    = 37;
    localparam int DEF_INT_W   = 11;
    localparam int DEF_FRAC_W  = 11;
    localparam int DEF_DIVISOR = 50;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } tdc_state_e;

endpackage

// File: rtl/ts_split_x50.sv
// ts_split_x50: splits a timestamp into coarse (quotient) and fine (remainder) counts
// with a bit-serial restoring divider, one quotient bit per cycle.
module ts_split_x50
    import tdc_pkg::*;
#(
    parameter int TS_W    = DEF_TS_W,
    parameter int INT_W   = DEF_INT_W,
    parameter int FRAC_W  = DEF_FRAC_W,
    parameter int DIVISOR = DEF_DIVISOR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TS_W-1:0]   ts_data,
    input  logic              start,
    output logic              busy,
    output logic [INT_W-1:0]  int_data,
    output logic [FRAC_W-1:0] frac_data,
    output logic              ovf,
    output logic              out_dval,
    output logic              drop
);

    localparam int REM_W = $clog2(2 * DIVISOR);
    localparam int CNT_W = $clog2(TS_W);
    localparam logic [REM_W-1:0] DIV_C   = REM_W'(DIVISOR);
    localparam logic [INT_W-1:0] INT_SAT = '1;

    tdc_state_e         r_state;
    logic [TS_W-1:0]    r_ts;
    logic [TS_W-1:0]    r_quo;
    logic [REM_W-1:0]   r_rem;
    logic [CNT_W-1:0]   r_cnt;

    logic [REM_W-1:0]   w_shift;
    logic               w_ge;
    logic               w_ovf;

    // Stored remainder is always < DIVISOR, so its top bit is free for the shift.
    assign w_shift = {r_rem[REM_W-2:0], r_ts[TS_W-1]};
    assign w_ge    = w_shift >= DIV_C;
    assign w_ovf   = |r_quo[TS_W-1:INT_W];
    assign busy    = r_state != IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_ts      <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            int_data  <= '0;
            frac_data <= '0;
            ovf       <= 1'b0;
            out_dval  <= 1'b0;
            drop      <= 1'b0;
        end else begin
            out_dval <= 1'b0;
            drop     <= start && busy;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_ts    <= ts_data;
                        r_quo   <= '0;
                        r_rem   <= '0;
                        r_cnt   <= CNT_W'(TS_W - 1);
                        r_state <= DIV;
                    end
                end
                DIV: begin
                    r_ts  <= {r_ts[TS_W-2:0], 1'b0};
                    r_rem <= w_ge ? w_shift - DIV_C : w_shift;
                    r_quo <= {r_quo[TS_W-2:0], w_ge};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0)
                        r_state <= DONE;
                end
                DONE: begin
                    int_data  <= w_ovf ? INT_SAT : r_quo[INT_W-1:0];
                    frac_data <= FRAC_W'(r_rem);
                    ovf       <= w_ovf;
                    out_dval  <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
